// File: rtl/bldc_hall_pkg.sv
// Shared Hall-sensor constants and 6-step sequence helpers for the BLDC front end.
package bldc_hall_pkg;

  // Codes that can never occur on a healthy 120-degree Hall set.
  localparam logic [2:0] HALL_ILLEGAL_LO = 3'b000;
  localparam logic [2:0] HALL_ILLEGAL_HI = 3'b111;

  // Defaults sized for a 50 MHz clk_sys: 10 us glitch window, 1 s stall timeout.
  localparam int unsigned FILT_CYCLES_DEF  = 500;
  localparam int unsigned STALL_CYCLES_DEF = 32'h02FA_F080;

  // Forward order: 001->011->010->110->100->101->001.
  // Illegal codes map to 000, which never equals a legal successor.
  function automatic logic [2:0] hall_next_fwd(input logic [2:0] s);
    case (s)
      3'b001:  return 3'b011;
      3'b011:  return 3'b010;
      3'b010:  return 3'b110;
      3'b110:  return 3'b100;
      3'b100:  return 3'b101;
      3'b101:  return 3'b001;
      default: return 3'b000;
    endcase
  endfunction

  // Reverse order is the inverse of hall_next_fwd.
  function automatic logic [2:0] hall_next_rev(input logic [2:0] s);
    case (s)
      3'b011:  return 3'b001;
      3'b010:  return 3'b011;
      3'b110:  return 3'b010;
      3'b100:  return 3'b110;
      3'b101:  return 3'b100;
      3'b001:  return 3'b101;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic hall_is_illegal(input logic [2:0] s);
    return (s == HALL_ILLEGAL_LO) || (s == HALL_ILLEGAL_HI);
  endfunction

endpackage

// File: rtl/hall_glitch_filter.sv
// Synchronizes an asynchronous vector and flags when a new value has been
// stable for FILT_CYCLES cycles. The whole vector is filtered as one word so
// that a multi-bit transition is only accepted once every bit has settled.
module hall_glitch_filter
  import bldc_hall_pkg::*;
#(
  parameter int unsigned W           = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_W      = 10,
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic         clk_sys,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  input  logic [W-1:0] accepted_i,
  output logic [W-1:0] cand_o,
  output logic         accept_o
);

  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILT_CYCLES - 1);

  logic [SYNC_STAGES-1:0][W-1:0] sync_q;
  logic [W-1:0]                  cand_q;
  logic [FILT_W-1:0]             cnt_q, cnt_d;
  logic [W-1:0]                  sync_vec;

  assign sync_vec = sync_q[SYNC_STAGES-1];

  // Stability counter: restart on any difference, saturate at the threshold.
  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    cnt_d = '0;
    if (sync_vec == cand_q) begin
      cnt_d = (cnt_q == FILT_LAST) ? cnt_q : cnt_q + FILT_W'(1);
    end
  end

  // Synchronizer chain, candidate register and stability counter.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      cand_q <= sync_vec;
      cnt_q  <= cnt_d;
    end
  end

  assign cand_o   = cand_q;
  assign accept_o = (cnt_q == FILT_LAST) && (cand_q != accepted_i);

endmodule

// File: rtl/hall_sensor_conditioner.sv
// Hall front end: filtered state, 6-step validation, direction, commutation
// strobe, clean Hall A clock for speed measurement, and stall detection.
module hall_sensor_conditioner
  import bldc_hall_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FILT_W       = 10,
  parameter int unsigned FILT_CYCLES  = FILT_CYCLES_DEF,
  parameter int unsigned STALL_W      = 26,
  parameter int unsigned STALL_CYCLES = STALL_CYCLES_DEF
) (
  input  logic       clk_sys,
  input  logic       rst,
  input  logic       hall_a,
  input  logic       hall_b,
  input  logic       hall_c,
  output logic [2:0] hall_state,
  output logic       hall_valid,
  output logic       hall_clk,
  output logic       edge_pulse,
  output logic       direction,
  output logic       seq_error,
  output logic       invalid_seen,
  output logic       stalled
);

  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_CYCLES - 1);

  logic [2:0]         cand;
  logic               accept;

  logic [2:0]         hall_state_q, hall_state_d;
  logic               hall_valid_q, hall_valid_d;
  logic               have_prev_q, have_prev_d;
  logic               hall_clk_q, hall_clk_d;
  logic               edge_pulse_q, edge_pulse_d;
  logic               direction_q, direction_d;
  logic               seq_error_q, seq_error_d;
  logic               invalid_seen_q, invalid_seen_d;
  logic               stalled_q, stalled_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

  hall_glitch_filter #(
    .W           (3),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W),
    .FILT_CYCLES (FILT_CYCLES)
  ) u_filter (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .async_i    ({hall_c, hall_b, hall_a}),
    .accepted_i (hall_state_q),
    .cand_o     (cand),
    .accept_o   (accept)
  );

  // Classify each accepted code against the previous one and run the stall timer.
  always_comb begin
    hall_state_d   = hall_state_q;
    hall_valid_d   = hall_valid_q;
    have_prev_d    = have_prev_q;
    direction_d    = direction_q;
    invalid_seen_d = invalid_seen_q;
    edge_pulse_d   = 1'b0;
    seq_error_d    = 1'b0;
    hall_clk_d     = hall_state_q[0];
    stall_cnt_d    = stall_cnt_q;
    stalled_d      = stalled_q;

    if (accept) begin
      hall_state_d = cand;
      if (hall_is_illegal(cand)) begin
        hall_valid_d   = 1'b0;
        invalid_seen_d = 1'b1;
        have_prev_d    = 1'b0;
      end else if (!have_prev_q) begin
        // First legal code after reset or an illegal code: lock, no edge.
        hall_valid_d = 1'b1;
        have_prev_d  = 1'b1;
      end else if (cand == hall_next_fwd(hall_state_q)) begin
        edge_pulse_d = 1'b1;
        direction_d  = 1'b1;
      end else if (cand == hall_next_rev(hall_state_q)) begin
        edge_pulse_d = 1'b1;
        direction_d  = 1'b0;
      end else begin
        // Skipped step: flag it and take the new code as the reference.
        seq_error_d = 1'b1;
      end
    end

    // An edge in the threshold cycle wins over the stall assertion.
    if (edge_pulse_d) begin
      stall_cnt_d = '0;
      stalled_d   = 1'b0;
    end else if (stall_cnt_q == STALL_LAST) begin
      stalled_d = 1'b1;
    end else begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  // State and output registers, synchronous reset.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      hall_state_q   <= '0;
      hall_valid_q   <= 1'b0;
      have_prev_q    <= 1'b0;
      hall_clk_q     <= 1'b0;
      edge_pulse_q   <= 1'b0;
      direction_q    <= 1'b0;
      seq_error_q    <= 1'b0;
      invalid_seen_q <= 1'b0;
      stalled_q      <= 1'b0;
      stall_cnt_q    <= '0;
    end else begin
      hall_state_q   <= hall_state_d;
      hall_valid_q   <= hall_valid_d;
      have_prev_q    <= have_prev_d;
      hall_clk_q     <= hall_clk_d;
      edge_pulse_q   <= edge_pulse_d;
      direction_q    <= direction_d;
      seq_error_q    <= seq_error_d;
      invalid_seen_q <= invalid_seen_d;
      stalled_q      <= stalled_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  assign hall_state   = hall_state_q;
  assign hall_valid   = hall_valid_q;
  assign hall_clk     = hall_clk_q;
  assign edge_pulse   = edge_pulse_q;
  assign direction    = direction_q;
  assign seq_error    = seq_error_q;
  assign invalid_seen = invalid_seen_q;
  assign stalled      = stalled_q;

endmodule

// File: tb/tb_hall_sensor_conditioner.sv
// Directed bench for hall_sensor_conditioner with FILT_CYCLES=4, STALL_CYCLES=100.
module tb_hall_sensor_conditioner;

  logic       clk_sys = 1'b0;
  logic       rst;
  logic       hall_a, hall_b, hall_c;
  logic [2:0] hall_state;
  logic       hall_valid, hall_clk, edge_pulse, direction;
  logic       seq_error, invalid_seen, stalled;

  int n_cmp = 0;
  int n_bad = 0;
  int ep_cnt;
  int se_cnt;
  int lag_bad;

  hall_sensor_conditioner #(
    .SYNC_STAGES  (2),
    .FILT_W       (10),
    .FILT_CYCLES  (4),
    .STALL_W      (26),
    .STALL_CYCLES (100)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .hall_a       (hall_a),
    .hall_b       (hall_b),
    .hall_c       (hall_c),
    .hall_state   (hall_state),
    .hall_valid   (hall_valid),
    .hall_clk     (hall_clk),
    .edge_pulse   (edge_pulse),
    .direction    (direction),
    .seq_error    (seq_error),
    .invalid_seen (invalid_seen),
    .stalled      (stalled)
  );

  always #5 clk_sys = ~clk_sys;

  // Apply a new raw vector {c,b,a} just after a rising edge.
  task automatic drive(input logic [2:0] v);
    @(posedge clk_sys);
    #1;
    {hall_c, hall_b, hall_a} = v;
  endtask

  // Sample n falling edges, counting strobes and checking the hall_clk lag.
  task automatic watch(input int n);
    logic prev_b0;
    bit   prev_ok;
    prev_ok = 1'b0;
    prev_b0 = 1'b0;
    ep_cnt  = 0;
    se_cnt  = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_sys);
      ep_cnt += int'(edge_pulse);
      se_cnt += int'(seq_error);
      if (prev_ok && (hall_clk !== prev_b0)) lag_bad++;
      prev_b0 = hall_state[0];
      prev_ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    {hall_c, hall_b, hall_a} = 3'b000;
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    n_cmp++;
    if ({hall_state, hall_valid, hall_clk, edge_pulse, direction, seq_error, invalid_seen, stalled} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0", {hall_state, hall_valid, hall_clk, edge_pulse,
               direction, seq_error, invalid_seen, stalled});
    end
  endtask

  task automatic test_first_lock;
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    {hall_c, hall_b, hall_a} = 3'b001;
    watch(7);
    n_cmp++;
    if (ep_cnt != 0 || hall_state !== 3'b000) begin
      n_bad++;
      $display("FAIL lock_early: state=%b edges=%0d want state=000 edges=0", hall_state, ep_cnt);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (hall_state !== 3'b001 || hall_valid !== 1'b1 || edge_pulse !== 1'b0 || hall_clk !== 1'b0) begin
      n_bad++;
      $display("FAIL lock: state=%b valid=%b edge=%b hclk=%b want 001 1 0 0",
               hall_state, hall_valid, edge_pulse, hall_clk);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (hall_clk !== 1'b1) begin
      n_bad++;
      $display("FAIL lock_hall_clk: got %b want 1", hall_clk);
    end
  endtask

  task automatic test_forward;
    logic [2:0] seq [6];
    int         edges;
    int         errs;
    seq   = '{3'b011, 3'b010, 3'b110, 3'b100, 3'b101, 3'b001};
    edges = 0;
    errs  = 0;
    lag_bad = 0;
    for (int i = 0; i < 6; i++) begin
      drive(seq[i]);
      watch(20);
      edges += ep_cnt;
      errs  += se_cnt;
      n_cmp++;
      if (hall_state !== seq[i]) begin
        n_bad++;
        $display("FAIL fwd_state[%0d]: got %b want %b", i, hall_state, seq[i]);
      end
    end
    n_cmp++;
    if (edges != 6 || errs != 0 || direction !== 1'b1) begin
      n_bad++;
      $display("FAIL fwd_summary: edges=%0d seqerr=%0d dir=%b want 6 0 1", edges, errs, direction);
    end
    n_cmp++;
    if (lag_bad != 0) begin
      n_bad++;
      $display("FAIL fwd_hall_clk_lag: %0d bad samples want 0", lag_bad);
    end
  endtask

  task automatic test_reverse;
    drive(3'b011);
    watch(20);
    drive(3'b001);
    watch(20);
    n_cmp++;
    if (ep_cnt != 1 || direction !== 1'b0 || hall_state !== 3'b001 || se_cnt != 0) begin
      n_bad++;
      $display("FAIL reverse: edges=%0d dir=%b state=%b seqerr=%0d want 1 0 001 0",
               ep_cnt, direction, hall_state, se_cnt);
    end
  endtask

  task automatic test_glitch_and_invalid;
    drive(3'b011);
    watch(20);
    drive(3'b111);
    watch(2);
    drive(3'b011);
    watch(20);
    n_cmp++;
    if (hall_state !== 3'b011 || invalid_seen !== 1'b0 || ep_cnt != 0) begin
      n_bad++;
      $display("FAIL glitch: state=%b inv=%b edges=%0d want 011 0 0", hall_state, invalid_seen, ep_cnt);
    end
    drive(3'b111);
    watch(20);
    n_cmp++;
    if (hall_state !== 3'b111 || hall_valid !== 1'b0 || invalid_seen !== 1'b1 || ep_cnt != 0) begin
      n_bad++;
      $display("FAIL invalid_hold: state=%b valid=%b inv=%b edges=%0d want 111 0 1 0",
               hall_state, hall_valid, invalid_seen, ep_cnt);
    end
    drive(3'b010);
    watch(20);
    n_cmp++;
    if (hall_state !== 3'b010 || hall_valid !== 1'b1 || ep_cnt != 0 || se_cnt != 0 || invalid_seen !== 1'b1) begin
      n_bad++;
      $display("FAIL relock: state=%b valid=%b edges=%0d seqerr=%0d inv=%b want 010 1 0 0 1",
               hall_state, hall_valid, ep_cnt, se_cnt, invalid_seen);
    end
  endtask

  task automatic test_seq_error;
    drive(3'b011);
    watch(20);
    drive(3'b001);
    watch(20);
    n_cmp++;
    if (direction !== 1'b0 || hall_state !== 3'b001) begin
      n_bad++;
      $display("FAIL jump_setup: dir=%b state=%b want 0 001", direction, hall_state);
    end
    drive(3'b110);
    watch(20);
    n_cmp++;
    if (se_cnt != 1 || ep_cnt != 0 || direction !== 1'b0 || hall_state !== 3'b110 || hall_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL jump: seqerr=%0d edges=%0d dir=%b state=%b valid=%b want 1 0 0 110 1",
               se_cnt, ep_cnt, direction, hall_state, hall_valid);
    end
  endtask

  task automatic test_stall;
    drive(3'b100);
    watch(7);
    @(negedge clk_sys);
    n_cmp++;
    if (edge_pulse !== 1'b1 || direction !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_edge: edge=%b dir=%b want 1 1", edge_pulse, direction);
    end
    watch(98);
    @(negedge clk_sys);
    n_cmp++;
    if (stalled !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_early: got %b want 0", stalled);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (stalled !== 1'b1) begin
      n_bad++;
      $display("FAIL stall_assert: got %b want 1", stalled);
    end
    drive(3'b101);
    watch(6);
    @(negedge clk_sys);
    n_cmp++;
    if (stalled !== 1'b1 || edge_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_held: stalled=%b edge=%b want 1 0", stalled, edge_pulse);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (edge_pulse !== 1'b1 || stalled !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_clear: edge=%b stalled=%b want 1 0", edge_pulse, stalled);
    end
    @(negedge clk_sys);
    n_cmp++;
    if (edge_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL edge_width: got %b want 0", edge_pulse);
    end
  endtask

  task automatic test_mid_reset;
    drive(3'b001);
    watch(3);
    @(posedge clk_sys);
    #1;
    rst = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    n_cmp++;
    if ({hall_state, hall_valid, hall_clk, edge_pulse, direction, seq_error, invalid_seen, stalled} !== 10'b0) begin
      n_bad++;
      $display("FAIL mid_reset: got %b want 0", {hall_state, hall_valid, hall_clk, edge_pulse,
               direction, seq_error, invalid_seen, stalled});
    end
    @(posedge clk_sys);
    #1;
    rst = 1'b0;
    watch(20);
    n_cmp++;
    if (hall_state !== 3'b001 || hall_valid !== 1'b1 || ep_cnt != 0 || se_cnt != 0 || invalid_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_lock: state=%b valid=%b edges=%0d seqerr=%0d inv=%b want 001 1 0 0 0",
               hall_state, hall_valid, ep_cnt, se_cnt, invalid_seen);
    end
  endtask

  initial begin
    lag_bad = 0;
    test_reset();
    test_first_lock();
    test_forward();
    test_reverse();
    test_glitch_and_invalid();
    test_seq_error();
    test_stall();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hall_sensor_conditioner.md
Name: hall_sensor_conditioner

Overview:
Front-end stage that feeds speed_computation and the commutation logic.
- Brings the three asynchronous Hall inputs into the clk_sys domain and glitch-filters them as one 3-bit vector.
- Validates each accepted state against the 6-step sequence and derives rotation direction.
- Emits a one-cycle commutation strobe, a clean Hall A signal (hall_clk, which drives speed_computation's Hall_sensor input), and stall/error flags.

Parameters:
SYNC_STAGES, 2, synchronizer depth (>=2)
FILT_W, 10, width of glitch-filter counter
FILT_CYCLES, 500, cycles a new vector must be stable before acceptance (10 us at 50 MHz); 1..2^FILT_W-1
STALL_W, 26, width of stall counter
STALL_CYCLES, 26'h2faf080, cycles without an accepted edge before stalled asserts (1 s at 50 MHz)

Ports:
clk_sys  in  1  50 MHz system clock
rst  in  1  synchronous, active-high reset
hall_a  in  1  raw Hall A, asynchronous
hall_b  in  1  raw Hall B, asynchronous
hall_c  in  1  raw Hall C, asynchronous
hall_state  out  3  filtered vector {c,b,a}
hall_valid  out  1  hall_state is a legal code (001..110)
hall_clk  out  1  filtered Hall A, registered; feeds speed_computation Hall_sensor
edge_pulse  out  1  one-cycle strobe per legal adjacent transition
direction  out  1  1 = forward, 0 = reverse
seq_error  out  1  one-cycle strobe on an illegal transition between valid codes
invalid_seen  out  1  sticky; set when 000 or 111 is accepted
stalled  out  1  no edge_pulse for STALL_CYCLES cycles

Behaviour:
- Reset, one clock only: clk_sys. Reset is synchronous and active-high.
  - Reset clears all outputs, all sync flops, the candidate register and all counters to 0.
  - The "have previous valid state" flag is cleared.
- Sync: SYNC_STAGES flops per bit; sync_vec is the last stage.
- Filter:
  - cand <= sync_vec every cycle.
  - If sync_vec != cand, cnt <= 0; otherwise cnt increments, saturating at FILT_CYCLES-1.
  - Accept when cnt == FILT_CYCLES-1 and cand != hall_state: hall_state <= cand next cycle.
  - Latency, clean input step to hall_state update: SYNC_STAGES+FILT_CYCLES+1 cycles.
  - Any bounce inside the window restarts the count. A pulse shorter than FILT_CYCLES is never accepted.
- Forward sequence: 001->011->010->110->100->101->001. Reverse is the inverse order.
- On acceptance of new code N with previous accepted code P:
  - N is 000 or 111: hall_valid<=0, invalid_seen<=1, prev-valid flag cleared. No edge_pulse. direction held.
  - N is valid and there is no prev-valid: hall_valid<=1, prev-valid set. No edge_pulse (first lock).
  - N == fwd(P): edge_pulse=1, direction<=1.
  - N == rev(P): edge_pulse=1, direction<=0.
  - Otherwise (N is valid but not adjacent to P): seq_error=1, no edge_pulse, direction held. N becomes the new reference.
- edge_pulse and seq_error are asserted in the same cycle hall_state updates; both are exactly one cycle wide.
- hall_clk <= hall_state[0] registered, i.e. one cycle after hall_state.
- Stall counter:
  - Clears on edge_pulse; otherwise increments, saturating.
  - stalled <= 1 when the count reaches STALL_CYCLES-1 and is held until the next edge_pulse.
  - An edge_pulse in the threshold cycle wins: counter cleared, stalled 0.
- Reset mid-filter discards the candidate; the next acceptance after reset is a first lock.

Decomposition:
- Package bldc_hall_pkg holds:
  - HALL_ILLEGAL_LO=3'b000 and HALL_ILLEGAL_HI=3'b111;
  - functions hall_next_fwd(3b) and hall_next_rev(3b);
  - default FILT_CYCLES and STALL_CYCLES constants.
- Sub-module hall_glitch_filter (sync + cand/cnt + accept strobe, vector width parameterised). Top level holds sequence/direction/stall logic.

Test Plan (FILT_CYCLES=4, STALL_CYCLES=100 on bench):
- Reset, then hold 001 -> after SYNC_STAGES+5 cycles hall_state=001, hall_valid=1, no edge_pulse.
- Forward steps 001->011->010->110->100->101->001, each held 20 cycles -> 6 edge_pulses, direction=1, seq_error=0, hall_clk follows bit0 one cycle late.
- From 011 step to 001 -> one edge_pulse, direction=0.
- 2-cycle glitch 011->111->011 -> no hall_state change, invalid_seen=0. Then hold 111 -> hall_valid=0, invalid_seen=1; next 010 -> no edge_pulse (first lock).
- Jump 001->110 -> seq_error one cycle, no edge_pulse, direction unchanged.
- No transitions for 100 cycles -> stalled=1 at cycle 100. Next legal edge -> stalled=0 in the edge_pulse cycle. Assert rst mid-window -> all outputs 0 next cycle.
